mdu_e: RTL

Execute-stage multiply/divide unit that consumes the multiply/divide operation code issued by the E-stage controller and the forwarded rs/rt operands. It runs `mult`, `multu`, `div` and `divu` over several cycles, owns the architectural HI/LO registers, and handles the single-cycle `mthi` and `mtlo` writes. While an operation is running it raises `busy`, which the hazard logic uses to stall any HI/LO-dependent or multiply/divide instruction held in D.

---
 rtl/mdu_e.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mdu_e.sv
// Execute-stage multiply/divide unit: multi-cycle mult/multu/div/divu with a fixed latency,
// single-cycle mthi/mtlo, and ownership of the architectural HI/LO registers.
module mdu_e #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  MD_OP,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        start,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [31:0]    r_a;
   logic [31:0]    r_b;
   logic [2:0]     r_op;
   logic           r_busy;
   logic [31:0]    r_hi;
   logic [31:0]    r_lo;

   logic [63:0]    w_prod_s;
   logic [63:0]    w_prod_u;
   logic           w_div_zero;
   logic           w_div_ovf;
   logic [31:0]    w_sdivisor;
   logic [31:0]    w_udivisor;
   logic [31:0]    w_quo_s;
   logic [31:0]    w_rem_s;
   logic [31:0]    w_quo_u;
   logic [31:0]    w_rem_u;

   // Combinational datapath over the latched operands; only sampled on the commit edge.
   assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

   // Dividing by 1 instead of -1 yields exactly 0x80000000 rem 0 for the overflow case,
   // and a divisor of 1 for B == 0 keeps the unused result free of X.
   assign w_div_zero = (r_b == 32'd0);
   assign w_div_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
   assign w_sdivisor = (w_div_zero || w_div_ovf) ? 32'd1 : r_b;
   assign w_udivisor = w_div_zero ? 32'd1 : r_b;
   assign w_quo_s    = $signed(r_a) / $signed(w_sdivisor);
   assign w_rem_s    = $signed(r_a) % $signed(w_sdivisor);
   assign w_quo_u    = r_a / w_udivisor;
   assign w_rem_u    = r_a % w_udivisor;

   assign start = (r_state == S_IDLE) && (MD_OP >= OP_MULT) && (MD_OP <= OP_DIVU);
   assign busy  = r_busy;
   assign HI    = r_hi;
   assign LO    = r_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               case (MD_OP)
                  OP_MULT, OP_MULTU: begin
                     r_a     <= A;
                     r_b     <= B;
                     r_op    <= MD_OP;
                     r_cnt   <= MUL_N;
                     r_busy  <= 1'b1;
                     r_state <= S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     r_a     <= A;
                     r_b     <= B;
                     r_op    <= MD_OP;
                     r_cnt   <= DIV_N;
                     r_busy  <= 1'b1;
                     r_state <= S_DIV;
                  end
                  OP_MTHI: r_hi <= A;
                  OP_MTLO: r_lo <= A;
                  default: ;
               endcase
            end
            S_MUL, S_DIV: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                  case (r_op)
                     OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                     OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                     OP_DIV: if (!w_div_zero) begin
                        r_hi <= w_rem_s;
                        r_lo <= w_quo_s;
                     end
                     OP_DIVU: if (!w_div_zero) begin
                        r_hi <= w_rem_u;
                        r_lo <= w_quo_u;
                     end
                     default: ;
                  endcase
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
